// File: rtl/cpu_pkg.sv
// Shared CPU constants: memory geometry, opcodes, controller state and error codes.
package cpu_pkg;

  localparam int unsigned Depth = 64;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned DataW = 16;
  localparam int unsigned CntW  = AddrW + 1;

  // 3-bit opcode field in the top bits of every instruction word.
  typedef enum logic [2:0] {
    OpLda = 3'd0,
    OpSta = 3'd1,
    OpAdd = 3'd2,
    OpSub = 3'd3,
    OpJmp = 3'd4,
    OpJz  = 3'd5,
    OpLdi = 3'd6,
    OpHlt = 3'd7
  } opcode_e;

  // Returned to the CPU whenever a fetch is not permitted.
  localparam logic [DataW-1:0] HltWord = {OpHlt, 13'd0};

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StVerify,
    StRun,
    StFault
  } ctrl_state_e;

  typedef enum logic [1:0] {
    ErrNone = 2'd0,
    ErrOvf  = 2'd1,
    ErrCsum = 2'd2
  } err_code_e;

endpackage

// File: rtl/imem_load_ctrl_if.sv
// Loader stream, CPU fetch bus and instruction-memory bus seen by the load controller.
interface imem_load_ctrl_if;
  import cpu_pkg::*;

  logic             ld_start;
  logic             ld_valid;
  logic [DataW-1:0] ld_data;
  logic             ld_last;
  logic             ld_ready;

  logic [15:0]      cpu_abus;
  logic [DataW-1:0] cpu_dbus;
  logic             cpu_run;

  logic             mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic [DataW-1:0] mem_rdata;

  // Environment side: loader, CPU and memory.
  modport master (
    output ld_start, ld_valid, ld_data, ld_last, cpu_abus, mem_rdata,
    input  ld_ready, cpu_dbus, cpu_run, mem_we, mem_addr, mem_wdata
  );

  // Controller side.
  modport slave (
    input  ld_start, ld_valid, ld_data, ld_last, cpu_abus, mem_rdata,
    output ld_ready, cpu_dbus, cpu_run, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_checksum.sv
// Wrapping additive accumulator with synchronous clear (clear wins over add).
module imem_checksum import cpu_pkg::*; (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             add_i,
  input  logic [DataW-1:0] data_i,
  output logic [DataW-1:0] value_o
);

  logic [DataW-1:0] sum_q, sum_d;

  // Next accumulator value, mod 2^DataW.
  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + data_i;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign value_o = sum_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Program-load and fetch controller: streams a program into instruction memory, reads it
// back against the load checksum, then releases the CPU onto the memory.
module imem_load_ctrl import cpu_pkg::*; (
  input  logic                 clk,
  input  logic                 reset,
  imem_load_ctrl_if.slave      bus,
  output logic [CntW-1:0]      ld_count,
  output logic [DataW-1:0]     checksum,
  output logic [1:0]           err_code
);

  ctrl_state_e      state_q;
  logic [AddrW-1:0] waddr_q;
  logic [AddrW-1:0] raddr_q;
  logic [CntW-1:0]  ld_count_q;
  err_code_e        err_q;
  logic             ld_ready_q;
  logic             cpu_run_q;

  logic             hs;
  logic             start_take;
  logic             verify_last;
  logic             csum_ok;
  logic             fetch_ok;
  logic [DataW-1:0] vsum;

  assign hs          = bus.ld_valid & ld_ready_q;
  assign start_take  = bus.ld_start & (state_q inside {StIdle, StRun, StFault});
  assign verify_last = (state_q == StVerify) && ({1'b0, raddr_q} == ld_count_q - CntW'(1));
  // Equality is evaluated at DataW bits, so the sum wraps like the load checksum.
  assign csum_ok     = ((vsum + bus.mem_rdata) == checksum);
  // ld_count never exceeds Depth, so this also rejects addresses beyond the memory.
  assign fetch_ok    = (bus.cpu_abus < 16'(ld_count_q));

  imem_checksum u_load_sum (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (start_take),
    .add_i   (hs),
    .data_i  (bus.ld_data),
    .value_o (checksum)
  );

  imem_checksum u_verify_sum (
    .clk_i   (clk),
    .rst_i   (reset),
    .clr_i   (hs & bus.ld_last),
    .add_i   (state_q == StVerify),
    .data_i  (bus.mem_rdata),
    .value_o (vsum)
  );

  // Controller FSM with counters and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      waddr_q    <= '0;
      raddr_q    <= '0;
      ld_count_q <= '0;
      err_q      <= ErrNone;
      ld_ready_q <= 1'b0;
      cpu_run_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StRun, StFault: begin
          if (start_take) begin
            state_q    <= StLoad;
            waddr_q    <= '0;
            err_q      <= ErrNone;
            ld_ready_q <= 1'b1;
            cpu_run_q  <= 1'b0;
          end
        end
        StLoad: begin
          if (hs) begin
            waddr_q <= waddr_q + 1'b1;
            if (bus.ld_last) begin
              state_q    <= StVerify;
              ld_count_q <= {1'b0, waddr_q} + 1'b1;
              raddr_q    <= '0;
              ld_ready_q <= 1'b0;
            end else if (waddr_q == AddrW'(Depth - 1)) begin
              // Last slot written without ld_last: the program does not fit.
              state_q    <= StFault;
              ld_count_q <= CntW'(Depth);
              err_q      <= ErrOvf;
              ld_ready_q <= 1'b0;
            end
          end
        end
        StVerify: begin
          raddr_q <= raddr_q + 1'b1;
          if (verify_last) begin
            if (csum_ok) begin
              state_q   <= StRun;
              cpu_run_q <= 1'b1;
            end else begin
              state_q <= StFault;
              err_q   <= ErrCsum;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory bus steering and CPU fetch data.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = waddr_q;
    bus.mem_wdata = bus.ld_data;
    bus.cpu_dbus  = HltWord;
    unique case (state_q)
      StLoad:   bus.mem_we = hs;
      StVerify: bus.mem_addr = raddr_q;
      StRun: begin
        bus.mem_addr = bus.cpu_abus[AddrW-1:0];
        if (fetch_ok) begin
          bus.cpu_dbus = bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.cpu_run  = cpu_run_q;
  assign ld_count     = ld_count_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Randomized self-checking bench for imem_load_ctrl with a behavioural program/memory model.
module tb_imem_load_ctrl;
  import cpu_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [CntW-1:0]  ld_count;
  logic [DataW-1:0] checksum;
  logic [1:0]       err_code;

  imem_load_ctrl_if bus ();

  imem_load_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .ld_count (ld_count),
    .checksum (checksum),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // Instruction memory: sync write, async read; optional corruption of word 3.
  logic [DataW-1:0] mem_model [Depth];
  bit               corrupt_en;
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem_model[bus.mem_addr] <= (corrupt_en && bus.mem_addr == 3) ? ~bus.mem_wdata
                                                                   : bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem_model[bus.mem_addr];

  int n_vec = 0;
  int n_err = 0;
  logic [DataW-1:0] prog_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: checksum and fetch result straight from the program contents.
  function automatic logic [DataW-1:0] model_sum();
    logic [DataW-1:0] s = '0;
    foreach (prog_q[i]) s = s + prog_q[i];
    return s;
  endfunction

  function automatic logic [DataW-1:0] model_fetch(input logic [15:0] a);
    return (int'(a) < prog_q.size()) ? prog_q[a] : HltWord;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ld_start with an optional simultaneous junk word that must not be accepted.
  task automatic start_load(input bit with_junk);
    bus.ld_start = 1'b1;
    bus.ld_valid = with_junk;
    bus.ld_data  = 16'($urandom);
    tick();
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input bit last, input bit gap);
    int cyc;
    if (gap) begin
      bus.ld_last = 1'($urandom);  // ld_last without ld_valid is ignored
      tick();
    end
    bus.ld_valid = 1'b1;
    bus.ld_data  = w;
    bus.ld_last  = last;
    cyc = 0;
    while (!bus.ld_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!bus.ld_ready) check_eq("ld_ready_timeout", 32'(bus.ld_ready), 32'd1);
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  task automatic load_prog(input bit use_last, input bit gap);
    foreach (prog_q[i]) send_word(prog_q[i], use_last && (i == prog_q.size() - 1), gap);
  endtask

  task automatic check_load(input string tag, input logic [1:0] exp_err);
    check_eq({tag, "_ld_count"}, 32'(ld_count), 32'(prog_q.size()));
    check_eq({tag, "_checksum"}, 32'(checksum), 32'(model_sum()));
    check_eq({tag, "_err_load"}, 32'(err_code), 32'(exp_err));
  endtask

  // Counts edges after the last handshake until cpu_run rises or an error appears.
  task automatic wait_verify(input string tag, input bit exp_run, input logic [1:0] exp_err);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!bus.cpu_run && err_code == 2'd0 && k < 200);
    check_eq({tag, "_verify_edges"}, 32'(k), 32'(prog_q.size()));
    check_eq({tag, "_cpu_run"}, 32'(bus.cpu_run), 32'(exp_run));
    check_eq({tag, "_err_verify"}, 32'(err_code), 32'(exp_err));
  endtask

  task automatic check_fetch(input string tag, input logic [15:0] a, input bit in_run);
    bus.cpu_abus = a;
    tick();
    check_eq(tag, 32'(bus.cpu_dbus), in_run ? 32'(model_fetch(a)) : 32'(HltWord));
  endtask

  task automatic random_fetches(input string tag, input int n, input bit in_run);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 90));
      check_fetch(tag, a, in_run);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DataW-1:0] mem_sum;
    logic [1:0]       exp_err;
    int               n;

    reset        = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.cpu_abus = '0;
    corrupt_en   = 1'b0;
    repeat (2) tick();
    check_eq("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check_eq("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_eq("rst_cpu_dbus", 32'(bus.cpu_dbus), 32'(HltWord));
    check_eq("rst_ld_count", 32'(ld_count), 32'd0);
    check_eq("rst_checksum", 32'(checksum), 32'd0);
    check_eq("rst_err", 32'(err_code), 32'd0);
    reset = 1'b0;
    tick();

    // Fixed 13-word program.
    prog_q = '{16'hC009, 16'h2000, 16'hC004, 16'h2001, 16'h0000, 16'h4001, 16'h2000,
               16'h0001, 16'h6001, 16'h2001, 16'hA00C, 16'h8004, 16'hE000};
    start_load(1'b1);
    load_prog(1'b1, 1'b0);
    check_eq("t1_ld_count_13", 32'(ld_count), 32'd13);
    check_eq("t1_checksum_a022", 32'(checksum), 32'hA022);
    check_load("t1", 2'd0);
    wait_verify("t1", 1'b1, 2'd0);

    // Fetches while running.
    check_fetch("t2_abus5", 16'd5, 1'b1);
    check_eq("t2_abus5_const", 32'(bus.cpu_dbus), 32'h4001);
    check_fetch("t2_abus12", 16'd12, 1'b1);
    check_eq("t2_abus12_const", 32'(bus.cpu_dbus), 32'hE000);
    check_fetch("t2_abus20", 16'd20, 1'b1);
    check_eq("t2_abus20_const", 32'(bus.cpu_dbus), 32'hE000);
    check_fetch("t2_abus77", 16'd77, 1'b1);
    random_fetches("t2_rand", 8, 1'b1);

    // Overflow: 64 words with no ld_last.
    prog_q.delete();
    for (int i = 0; i < Depth; i++) prog_q.push_back(16'($urandom));
    start_load(1'b1);
    check_eq("t3_run_drop", 32'(bus.cpu_run), 32'd0);
    load_prog(1'b0, 1'b0);
    check_load("t3", 2'd1);
    check_eq("t3_state", 32'(dut.state_q), 32'(StFault));
    check_eq("t3_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_eq("t3_ld_ready", 32'(bus.ld_ready), 32'd0);
    random_fetches("t3_dbus", 4, 1'b0);

    // Corrupted word 3 must fail verification.
    n = $urandom_range(5, 20);
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back(16'($urandom));
    corrupt_en = 1'b1;
    start_load(1'b0);
    load_prog(1'b1, 1'b0);
    corrupt_en = 1'b0;
    check_load("t4", 2'd0);
    mem_sum = '0;
    for (int i = 0; i < n; i++) mem_sum = mem_sum + mem_model[i];
    exp_err = (mem_sum != model_sum()) ? 2'd2 : 2'd0;
    wait_verify("t4", exp_err == 2'd0, exp_err);
    check_eq("t4_state", 32'(dut.state_q), 32'(StFault));
    random_fetches("t4_dbus", 3, 1'b0);

    // Reset in the middle of a load.
    start_load(1'b0);
    for (int i = 0; i < 3; i++) send_word(16'($urandom), 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("t5_ld_ready", 32'(bus.ld_ready), 32'd0);
    check_eq("t5_cpu_run", 32'(bus.cpu_run), 32'd0);
    check_eq("t5_state", 32'(dut.state_q), 32'(StIdle));
    check_eq("t5_ld_count", 32'(ld_count), 32'd0);
    check_eq("t5_checksum", 32'(checksum), 32'd0);
    check_eq("t5_err", 32'(err_code), 32'd0);
    check_eq("t5_waddr", 32'(dut.waddr_q), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Gapped random program, then reload from RUN with a full 64-word program.
    n = $urandom_range(1, 40);
    prog_q.delete();
    for (int i = 0; i < n; i++) prog_q.push_back(16'($urandom));
    start_load(1'b1);
    load_prog(1'b1, 1'b1);
    check_load("t6a", 2'd0);
    wait_verify("t6a", 1'b1, 2'd0);
    random_fetches("t6a_rand", 6, 1'b1);

    prog_q.delete();
    for (int i = 0; i < Depth; i++) prog_q.push_back(16'($urandom));
    start_load(1'b1);
    check_eq("t6_run_drop", 32'(bus.cpu_run), 32'd0);
    check_eq("t6_ready_up", 32'(bus.ld_ready), 32'd1);
    check_eq("t6_dbus_hlt", 32'(bus.cpu_dbus), 32'(HltWord));
    load_prog(1'b1, 1'b1);
    check_load("t6b", 2'd0);
    wait_verify("t6b", 1'b1, 2'd0);
    check_fetch("t6b_abus63", 16'd63, 1'b1);
    check_fetch("t6b_abus64", 16'd64, 1'b1);
    random_fetches("t6b_rand", 6, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
